// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: time-slices DIGITS hex digits onto one
// segment bus. Loaded values are double-buffered and swapped only at frame boundaries.
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [DIGITS*CNT_WIDTH-1:0]   digits_in,
    input  logic                          blank_lz,
    output logic [DIGITS-1:0]             an,
    output logic [6:0]                    seg,
    output logic                          frame_done
);

    localparam int RC_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Standard hex font, segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h3F;
            4'h1:    pattern = 7'h06;
            4'h2:    pattern = 7'h5B;
            4'h3:    pattern = 7'h4F;
            4'h4:    pattern = 7'h66;
            4'h5:    pattern = 7'h6D;
            4'h6:    pattern = 7'h7D;
            4'h7:    pattern = 7'h07;
            4'h8:    pattern = 7'h7F;
            4'h9:    pattern = 7'h6F;
            4'hA:    pattern = 7'h77;
            4'hB:    pattern = 7'h7C;
            4'hC:    pattern = 7'h39;
            4'hD:    pattern = 7'h5E;
            4'hE:    pattern = 7'h79;
            4'hF:    pattern = 7'h71;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    logic [RC_W-1:0]             refresh_cnt_r;
    logic [IDX_W-1:0]            index_r;
    logic [DIGITS*CNT_WIDTH-1:0] pending_r;
    logic [DIGITS*CNT_WIDTH-1:0] active_r;
    logic                        pending_flag_r;
    logic                        slot_wrap_s;
    logic                        frame_wrap_s;
    logic [CNT_WIDTH-1:0]        digit_s;
    logic [DIGITS-1:0]           zero_from_s;
    logic                        zero_run_s;
    logic                        blank_s;

    // Slot and frame boundary strobes.
    always_comb begin
        slot_wrap_s  = enable && (refresh_cnt_r == RC_LAST);
        frame_wrap_s = slot_wrap_s && (index_r == IDX_LAST);
    end

    // Refresh counter and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt_r <= {RC_W{1'b0}};
            index_r       <= {IDX_W{1'b0}};
        end else if (enable) begin
            refresh_cnt_r <= slot_wrap_s ? {RC_W{1'b0}} : refresh_cnt_r + RC_W'(1);
            if (frame_wrap_s) begin
                index_r <= {IDX_W{1'b0}};
            end else if (slot_wrap_s) begin
                index_r <= index_r + IDX_W'(1);
            end else begin
                index_r <= index_r;
            end
        end else begin
            refresh_cnt_r <= refresh_cnt_r;
            index_r       <= index_r;
        end
    end

    // Double buffer: a load at the frame edge bypasses pending; otherwise pending
    // is promoted at the next frame edge, or immediately while the scan is halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r      <= {(DIGITS*CNT_WIDTH){1'b0}};
            active_r       <= {(DIGITS*CNT_WIDTH){1'b0}};
            pending_flag_r <= 1'b0;
        end else if (load && frame_wrap_s) begin
            active_r       <= digits_in;
            pending_flag_r <= 1'b0;
        end else if (load) begin
            pending_r      <= digits_in;
            pending_flag_r <= 1'b1;
        end else if (pending_flag_r && (frame_wrap_s || !enable)) begin
            active_r       <= pending_r;
            pending_flag_r <= 1'b0;
        end else begin
            pending_flag_r <= pending_flag_r;
        end
    end

    // Current digit and leading-zero run (bit i set when digits i..top are all zero).
    always_comb begin
        digit_s     = active_r[int'(index_r)*CNT_WIDTH +: CNT_WIDTH];
        zero_run_s  = 1'b1;
        zero_from_s = {DIGITS{1'b0}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s     = zero_run_s && (active_r[i*CNT_WIDTH +: CNT_WIDTH] == {CNT_WIDTH{1'b0}});
            zero_from_s[i] = zero_run_s;
        end
        blank_s = blank_lz && (index_r != {IDX_W{1'b0}}) && zero_from_s[index_r];
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= {DIGITS{1'b1}};
            seg        <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap_s;
            if (!enable || blank_s) begin
                an  <= {DIGITS{1'b1}};
                seg <= 7'h00;
            end else begin
                an  <= ~(DIGITS'(1'b1) << index_r);
                seg <= hex_to_seg(4'(digit_s));
            end
        end
    end

endmodule
